// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among byte requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           TX_DATA,
  output logic                 TX_start,
  input  logic                 TX_busy,
  output logic [2:0]           owner,
  output logic                 active,
  output logic                 err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, win, idx;
  logic [IW:0] sum;
  logic found;
  logic [7:0] win_data, cnt_q, cnt_d, data_q, data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [2:0] owner_q, owner_d;
  logic start_q, start_d, err_q, err_d;
  // Search p, p+1, ... wrapping; the first requester seen high wins
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      idx = IW'(sum >= (IW+1)'(NUM_REQ) ? sum - (IW+1)'(NUM_REQ) : sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // Byte of the winning requester
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == IW'(i)) win_data = req_data[8*i +: 8];
  end
  // Frame sequencing: grant, wait for busy (or watchdog), drain, inter-frame gap
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    owner_d = owner_q;
    start_d = start_q;
    ack_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE:
        if (found && !TX_busy) begin
          ack_d   = NUM_REQ'(1) << win;
          data_d  = win_data;
          owner_d = 3'(win);
          ptr_d   = win == IW'(NUM_REQ-1) ? '0 : win + IW'(1);
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = START;
        end
      START:
        if (TX_busy) begin
          start_d = 1'b0;
          state_d = BUSY;
        end else if (cnt_q == 8'(BUSY_TIMEOUT-1)) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP_CYCLES == 0 ? IDLE : GAP;
        end else cnt_d = cnt_q + 8'd1;
      BUSY:
        if (!TX_busy) begin
          cnt_d   = '0;
          state_d = GAP_CYCLES == 0 ? IDLE : GAP;
        end
      GAP:
        if (cnt_q == 8'(GAP_CYCLES-1)) state_d = IDLE;
        else cnt_d = cnt_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  // State register; reset aborts any frame and drops TX_start at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      owner_q <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end
  assign ack         = ack_q;
  assign TX_DATA     = data_q;
  assign TX_start    = start_q;
  assign owner       = owner_q;
  assign active      = state_q != IDLE;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, corner sequences and randomized run against a timeline model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int T = 16;
  localparam int G = 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] ack;
  logic [7:0] TX_DATA;
  logic TX_start;
  logic TX_busy = 1'b0;
  logic [2:0] owner;
  logic active;
  logic err_timeout;
  int vectors = 0;
  int miscompares = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(T), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .TX_DATA(TX_DATA), .TX_start(TX_start), .TX_busy(TX_busy),
    .owner(owner), .active(active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic [3:0] req;
    logic busy;
    logic [3:0] ack;
    logic start;
    logic [7:0] data;
    logic [2:0] owner;
    logic act;
  } vec_t;
  vec_t tbl[25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    TX_busy = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // timeline model state
  int e, free_at, g_e, n, d;
  bit in_fr, bseen, got;
  int m_ptr, m_owner, w, j;
  logic [7:0] m_data;
  logic [3:0] exp_ack;
  logic exp_err, exp_start, exp_active;
  int tx_st, tx_cnt;

  initial begin
    tbl[0]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 1'b0, 4'h1, 1'b1, 8'h11, 3'd0, 1'b1};
    tbl[3]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 8'h11, 3'd0, 1'b1};
    tbl[4]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 8'h11, 3'd0, 1'b1};
    tbl[5]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 8'h11, 3'd0, 1'b1};
    tbl[6]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 8'h11, 3'd0, 1'b0};
    tbl[7]  = '{1'b1, 4'hF, 1'b0, 4'h2, 1'b1, 8'h22, 3'd1, 1'b1};
    tbl[8]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 8'h22, 3'd1, 1'b1};
    tbl[9]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 8'h22, 3'd1, 1'b1};
    tbl[10] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 8'h22, 3'd1, 1'b0};
    tbl[11] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 8'h22, 3'd1, 1'b0};
    tbl[12] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 8'h22, 3'd1, 1'b0};
    tbl[13] = '{1'b1, 4'hF, 1'b0, 4'h4, 1'b1, 8'h33, 3'd2, 1'b1};
    tbl[14] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 8'h33, 3'd2, 1'b1};
    tbl[15] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 8'h33, 3'd2, 1'b1};
    tbl[16] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 8'h33, 3'd2, 1'b0};
    tbl[17] = '{1'b1, 4'hF, 1'b0, 4'h8, 1'b1, 8'h44, 3'd3, 1'b1};
    tbl[18] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 8'h44, 3'd3, 1'b1};
    tbl[19] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 8'h44, 3'd3, 1'b1};
    tbl[20] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 8'h44, 3'd3, 1'b0};
    tbl[21] = '{1'b1, 4'hF, 1'b0, 4'h1, 1'b1, 8'h11, 3'd0, 1'b1};
    tbl[22] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 8'h11, 3'd0, 1'b1};
    tbl[23] = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[24] = '{1'b1, 4'h5, 1'b0, 4'h1, 1'b1, 8'h11, 3'd0, 1'b1};
    req_data = 32'h44332211;
    for (int i = 0; i < 25; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      TX_busy = tbl[i].busy;
      tick();
      chk($sformatf("tbl%0d ack", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d start", i), 32'(TX_start), 32'(tbl[i].start));
      chk($sformatf("tbl%0d data", i), 32'(TX_DATA), 32'(tbl[i].data));
      chk($sformatf("tbl%0d owner", i), 32'(owner), 32'(tbl[i].owner));
      chk($sformatf("tbl%0d active", i), 32'(active), 32'(tbl[i].act));
      chk($sformatf("tbl%0d err", i), 32'(err_timeout), 32'd0);
    end

    // single byte: start held 2 cycles, next grant GAP+1 edges after busy seen low
    do_reset();
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    req = 4'b0100;
    tick();
    chk("single ack", 32'(ack), 32'h4);
    chk("single data", 32'(TX_DATA), 32'hA5);
    chk("single owner", 32'(owner), 32'd2);
    chk("single start0", 32'(TX_start), 32'd1);
    req = '0;
    tick();
    chk("single ack_pulse", 32'(ack), 32'd0);
    chk("single start1", 32'(TX_start), 32'd1);
    TX_busy = 1'b1;
    tick();
    chk("single start2", 32'(TX_start), 32'd0);
    chk("single busy_active", 32'(active), 32'd1);
    repeat (10) tick();
    chk("single still_busy", 32'(active), 32'd1);
    TX_busy = 1'b0;
    req_data[23:16] = 8'h5A;
    req = 4'b0100;
    n = 0;
    while (n < 10 && ack == '0) begin
      tick();
      n++;
    end
    chk("gap latency", 32'(n), 32'(G + 2));
    chk("second ack", 32'(ack), 32'h4);
    chk("second data", 32'(TX_DATA), 32'h5A);

    // watchdog: no busy, start held T cycles, single err pulse, then requester 2 wins
    do_reset();
    req_data = 32'h44332211;
    req = 4'b0010;
    tick();
    chk("wd ack", 32'(ack), 32'h2);
    chk("wd start0", 32'(TX_start), 32'd1);
    req = 4'b0110;
    for (int i = 1; i < T; i++) begin
      tick();
      chk($sformatf("wd start%0d", i), 32'(TX_start), 32'd1);
      chk($sformatf("wd noerr%0d", i), 32'(err_timeout), 32'd0);
    end
    tick();
    chk("wd start_drop", 32'(TX_start), 32'd0);
    chk("wd err", 32'(err_timeout), 32'd1);
    chk("wd err_noack", 32'(ack), 32'd0);
    tick();
    chk("wd err_once", 32'(err_timeout), 32'd0);
    chk("wd gap_noack", 32'(ack), 32'd0);
    tick();
    chk("wd next_ack", 32'(ack), 32'h4);
    chk("wd next_owner", 32'(owner), 32'd2);

    // asynchronous reset in START: outputs clear without an edge, frame not resent
    rst = 1'b0;
    #1;
    chk("arst start", 32'(TX_start), 32'd0);
    chk("arst ack", 32'(ack), 32'd0);
    chk("arst data", 32'(TX_DATA), 32'd0);
    chk("arst owner", 32'(owner), 32'd0);
    chk("arst active", 32'(active), 32'd0);
    req = '0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst no_resend", 32'({ack, TX_start}), 32'd0);
    end

    // randomized run against a timeline model of grants, frames and gaps
    do_reset();
    e = 0; free_at = 0; g_e = 0; in_fr = 0; bseen = 0;
    m_ptr = 0; m_owner = 0; m_data = 8'h00;
    tx_st = 0; tx_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      e++;
      exp_ack = '0;
      exp_err = 1'b0;
      if (in_fr) begin
        if (!bseen) begin
          if (TX_busy) bseen = 1;
          else if (e - g_e == T) begin
            exp_err = 1'b1;
            in_fr = 0;
            free_at = e + G + 1;
          end
        end else if (!TX_busy) begin
          in_fr = 0;
          free_at = e + G + 1;
        end
      end else if (e >= free_at && req != '0 && !TX_busy) begin
        got = 0;
        w = 0;
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!got && req[j]) begin
            got = 1;
            w = j;
          end
        end
        exp_ack = 4'(1) << w;
        m_data = req_data[8*w +: 8];
        m_owner = w;
        m_ptr = (w + 1) % N;
        in_fr = 1;
        bseen = 0;
        g_e = e;
      end
      exp_start = in_fr && !bseen;
      exp_active = in_fr || (e < free_at - 1);
      tick();
      chk("rnd ack", 32'(ack), 32'(exp_ack));
      chk("rnd start", 32'(TX_start), 32'(exp_start));
      chk("rnd data", 32'(TX_DATA), 32'(m_data));
      chk("rnd owner", 32'(owner), 32'(m_owner));
      chk("rnd active", 32'(active), 32'(exp_active));
      chk("rnd err", 32'(err_timeout), 32'(exp_err));
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
      if (tx_st == 0 && TX_start) begin
        d = ($urandom_range(4, 0) == 0) ? int'($urandom_range(20, 12)) : int'($urandom_range(3, 1));
        tx_st = 1;
        tx_cnt = d;
      end else if (tx_st == 0 && $urandom_range(40, 0) == 0) begin
        tx_st = 2;
        tx_cnt = int'($urandom_range(5, 1));
        TX_busy = 1'b1;
      end else if (tx_st == 1) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          TX_busy = 1'b1;
          tx_st = 2;
          tx_cnt = int'($urandom_range(8, 1));
        end
      end else if (tx_st == 2) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          TX_busy = 1'b0;
          tx_st = 0;
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART `transmitter` among `NUM_REQ` byte requesters. It accepts one byte per grant, drives the transmitter's `TX_DATA` and `TX_start`, and tracks `TX_busy` through the frame. It also enforces an inter-frame gap and a start-acknowledge watchdog. It sits between the client logic and the `transmitter` instance in the UART top level.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 16: cycles allowed in START for `TX_busy` to rise, 2..255.
- `GAP_CYCLES`, 1: idle cycles enforced after `TX_busy` falls, 0..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  `NUM_REQ`  per-requester level request; held high with stable data until acked.
- `req_data`  in  `8*NUM_REQ`  byte for requester i in bits [8i+7:8i].
- `ack`  out  `NUM_REQ`  one-hot, one-cycle pulse; the byte has been taken.
- `TX_DATA`  out  8  byte to the transmitter; stable from grant until next grant.
- `TX_start`  out  1  start request to the transmitter; transmitter acts on its rising edge.
- `TX_busy`  in  1  transmitter busy flag.
- `owner`  out  3  index of the requester currently/last served.
- `active`  out  1  high in any state other than IDLE.
- `err_timeout`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- Reset (`rst`=0, async): state IDLE; `ack`=0, `TX_start`=0, `TX_DATA`=8'h00, `owner`=0, `active`=0, `err_timeout`=0; RR pointer=0 (requester 0 highest priority); counters cleared. Reset mid-frame aborts immediately; `TX_start` drops asynchronously.
- The RR search order starts at pointer p: p, p+1, …, `NUM_REQ`-1, 0, …. The first requester with `req` high wins. After a grant, p = winner+1 mod `NUM_REQ`.
- IDLE: grants only when some `req` is high and `TX_busy`=0. If `TX_busy` is high in IDLE (foreign or stuck transmitter), the arbiter waits without granting. On a grant, at the same edge: `ack[winner]`=1 for one cycle, `TX_DATA`←winner's byte, `owner`←winner, `TX_start`←1, counter←0, state→START.
- START: `TX_start` held high; the counter increments each cycle.
  - `TX_busy`=1 → `TX_start`←0, state→BUSY.
  - Otherwise, when the counter reaches `BUSY_TIMEOUT`-1 → `TX_start`←0, `err_timeout` pulse, state→GAP. The byte is dropped; there is no retry.
- BUSY: waits for `TX_busy`=0 → counter←0, state→GAP.
- GAP: counts `GAP_CYCLES`, then state→IDLE. With `GAP_CYCLES`=0, GAP lasts 0 cycles (BUSY/START exit goes directly to IDLE).
- `req` is sampled only in IDLE. A request dropped before its ack is simply not served. A request held high after its ack is treated as a new byte at the next arbitration.
- Requests arriving while not IDLE wait. There is no buffering beyond the requester's own hold.

## Timing
- Grant latency: `req` seen high at edge k in IDLE (transmitter idle) → `ack` and `TX_start` high from edge k, i.e. visible in cycle k+1.
- `TX_start` minimum high time is 1 cycle; it always returns low before the next grant. This guarantees a fresh rising edge per frame.
- Back-to-back frames: the next grant is no earlier than `GAP_CYCLES`+1 edges after `TX_busy` is seen low.
- Only one `ack` bit is high at any time. `ack` never coincides with `err_timeout`.
- `owner` and `TX_DATA` change only on a grant edge.
- Simultaneous `TX_busy` rise and timeout edge in START: BUSY wins, and there is no error.

## Test plan
- Reset: hold `rst`=0 with all `req` high → `ack`=0, `TX_start`=0, `TX_DATA`=8'h00, `active`=0. Release → first grant goes to requester 0.
- Single byte: `req[2]`=1 with data 8'hA5; the model raises `TX_busy` 2 cycles after `TX_start` and holds it 11 cycles.
  - Expect `ack`=4'b0100 for one cycle, `TX_DATA`=8'hA5, `TX_start` high for exactly 2 cycles, `owner`=2.
  - Expect the next grant no earlier than `GAP_CYCLES`+1 cycles after `TX_busy` falls.
- Fairness: all four `req` held high continuously → grant order 0,1,2,3,0,1…, with each `ack` exactly once per round.
- Watchdog: `req[1]`=1 with `TX_busy` tied 0 → `TX_start` high for 16 cycles, then `err_timeout` pulses once. Return to IDLE, after which requester 2 (if requesting) wins next.
- Stuck busy: `TX_busy`=1 in IDLE with `req[0]`=1 → no `ack` while busy. `TX_busy` falls → grant on the next edge.
- Mid-frame reset: assert `rst`=0 during BUSY → all outputs return to reset values immediately. After release the pointer is 0 and the dropped frame is not resent.
